// File: rtl/entity_vector_sequencer.sv
// Walks each active entity's vector ROM point list and drives the XY beam DAC, one frame per frame_start.
// Optional cursor slot (slot 4, always active) is compiled in with `define CURSOR_DRAW_EN.
//
// state  | meaning
// IDLE   | waiting for frame_start
// LATCH  | snapshot all entity inputs, slot <= 0
// SLOT   | skip inactive slot or load sprite start address
// REQ    | ROM read strobe at ptr
// WAIT   | ROM word arrives; compute, clamp and load beam outputs
// DWELL  | hold point for DWELL_CYCLES cycles, then next point or next slot
// NEXT   | beam off, advance slot
// DONE   | frame_done pulse
module entity_vector_sequencer #(
  parameter int OUT_WIDTH = 8,
  parameter int ADDRESSWIDTH = 16,
  parameter int FRAME_MIN = 0,
  parameter int FRAME_MAX = 255,
  parameter int DWELL_CYCLES = 4,
  parameter int MAX_POINTS = 64,
  parameter logic [ADDRESSWIDTH-1:0] ADR_MISSILE = 16'h0000
`ifdef CURSOR_DRAW_EN
  , parameter logic [ADDRESSWIDTH-1:0] ADR_CURSOR = 16'h0000
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_start,
  input  logic [OUT_WIDTH-1:0]      xenemy1,
  input  logic [OUT_WIDTH-1:0]      yenemy1,
  input  logic [OUT_WIDTH-1:0]      xenemy2,
  input  logic [OUT_WIDTH-1:0]      yenemy2,
  input  logic [OUT_WIDTH-1:0]      xenemy3,
  input  logic [OUT_WIDTH-1:0]      yenemy3,
  input  logic                      spawn_enemy1,
  input  logic                      spawn_enemy2,
  input  logic                      spawn_enemy3,
  input  logic [ADDRESSWIDTH-1:0]   adr_enemy1,
  input  logic [ADDRESSWIDTH-1:0]   adr_enemy2,
  input  logic [ADDRESSWIDTH-1:0]   adr_enemy3,
  input  logic [OUT_WIDTH-1:0]      x_missile,
  input  logic [OUT_WIDTH-1:0]      y_missile,
  input  logic                      spawn_missile,
  output logic [ADDRESSWIDTH-1:0]   rom_adr,
  output logic                      rom_en,
  input  logic [2*OUT_WIDTH+1:0]    rom_data,
  output logic [OUT_WIDTH-1:0]      x_out,
  output logic [OUT_WIDTH-1:0]      y_out,
  output logic                      beam_on,
  output logic                      busy,
  output logic                      frame_done
`ifdef CURSOR_DRAW_EN
  , input logic [OUT_WIDTH-1:0]     xcursor,
  input  logic [OUT_WIDTH-1:0]      ycursor
`endif
);

`ifdef CURSOR_DRAW_EN
  localparam int NSLOTS = 5;
`else
  localparam int NSLOTS = 4;
`endif
  localparam int W2 = OUT_WIDTH + 2;
  localparam int SW = $clog2(NSLOTS);
  localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int PW = $clog2(MAX_POINTS + 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(NSLOTS - 1);
  localparam logic [DW-1:0] DWELL_LOAD = DW'(DWELL_CYCLES - 1);
  localparam logic [PW-1:0] PT_LAST = PW'(MAX_POINTS - 1);
  localparam logic signed [W2-1:0] MIN_S = W2'(FRAME_MIN);
  localparam logic signed [W2-1:0] MAX_S = W2'(FRAME_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_SLOT, S_REQ, S_WAIT, S_DWELL, S_NEXT, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [OUT_WIDTH-1:0]    in_x [NSLOTS];
  logic [OUT_WIDTH-1:0]    in_y [NSLOTS];
  logic [ADDRESSWIDTH-1:0] in_adr [NSLOTS];
  logic [NSLOTS-1:0]       in_spawn;

  logic [OUT_WIDTH-1:0]    snap_x [NSLOTS];
  logic [OUT_WIDTH-1:0]    snap_y [NSLOTS];
  logic [ADDRESSWIDTH-1:0] snap_adr [NSLOTS];
  logic [NSLOTS-1:0]       snap_spawn;

  logic [SW-1:0]           slot;
  logic [ADDRESSWIDTH-1:0] ptr;
  logic [PW-1:0]           pt_cnt;
  logic [DW-1:0]           dwell_cnt;
  logic                    last_q;

  logic [OUT_WIDTH-1:0]    dx, dy;
  logic signed [W2-1:0]    sum_x, sum_y;
  logic                    dwell_tc, sprite_end;

  always_comb begin
    in_x[0] = xenemy1;  in_y[0] = yenemy1;  in_adr[0] = adr_enemy1;
    in_x[1] = xenemy2;  in_y[1] = yenemy2;  in_adr[1] = adr_enemy2;
    in_x[2] = xenemy3;  in_y[2] = yenemy3;  in_adr[2] = adr_enemy3;
    in_x[3] = x_missile; in_y[3] = y_missile; in_adr[3] = ADR_MISSILE;
`ifdef CURSOR_DRAW_EN
    in_x[4] = xcursor;  in_y[4] = ycursor;  in_adr[4] = ADR_CURSOR;
    in_spawn = {1'b1, spawn_missile, spawn_enemy3, spawn_enemy2, spawn_enemy1};
`else
    in_spawn = {spawn_missile, spawn_enemy3, spawn_enemy2, spawn_enemy1};
`endif
  end

  function automatic logic [OUT_WIDTH-1:0] clamp(input logic signed [W2-1:0] v);
    if (v < MIN_S) return MIN_S[OUT_WIDTH-1:0];
    if (v > MAX_S) return MAX_S[OUT_WIDTH-1:0];
    return v[OUT_WIDTH-1:0];
  endfunction

  // ROM word is {dx, dy, beam, last}; anchors are unsigned, offsets signed
  assign dx    = rom_data[2*OUT_WIDTH+1:OUT_WIDTH+2];
  assign dy    = rom_data[OUT_WIDTH+1:2];
  assign sum_x = $signed({2'b00, snap_x[slot]}) + $signed({{2{dx[OUT_WIDTH-1]}}, dx});
  assign sum_y = $signed({2'b00, snap_y[slot]}) + $signed({{2{dy[OUT_WIDTH-1]}}, dy});

  assign dwell_tc   = (dwell_cnt == '0);
  assign sprite_end = last_q || (pt_cnt == PT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    rom_en     = 1'b0;
    rom_adr    = '0;
    busy       = (state != S_IDLE);
    frame_done = 1'b0;
    case (state)
      S_IDLE:  if (frame_start) state_nxt = S_LATCH;
      S_LATCH: state_nxt = S_SLOT;
      S_SLOT:  state_nxt = snap_spawn[slot] ? S_REQ : S_NEXT;
      S_REQ: begin
        rom_en    = 1'b1;
        rom_adr   = ptr;
        state_nxt = S_WAIT;
      end
      S_WAIT:  state_nxt = S_DWELL;
      S_DWELL: if (dwell_tc) state_nxt = sprite_end ? S_NEXT : S_REQ;
      S_NEXT:  state_nxt = (slot == SLOT_LAST) ? S_DONE : S_SLOT;
      S_DONE: begin
        frame_done = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NSLOTS; i++) begin
        snap_x[i]   <= '0;
        snap_y[i]   <= '0;
        snap_adr[i] <= '0;
      end
      snap_spawn <= '0;
      slot       <= '0;
      ptr        <= '0;
      pt_cnt     <= '0;
      dwell_cnt  <= '0;
      last_q     <= 1'b0;
      x_out      <= '0;
      y_out      <= '0;
      beam_on    <= 1'b0;
    end else begin
      case (state)
        S_LATCH: begin
          snap_x     <= in_x;
          snap_y     <= in_y;
          snap_adr   <= in_adr;
          snap_spawn <= in_spawn;
          slot       <= '0;
        end
        S_SLOT: begin
          if (snap_spawn[slot]) begin
            ptr    <= snap_adr[slot];
            pt_cnt <= '0;
          end
        end
        S_WAIT: begin
          x_out     <= clamp(sum_x);
          y_out     <= clamp(sum_y);
          beam_on   <= rom_data[1];
          last_q    <= rom_data[0];
          dwell_cnt <= DWELL_LOAD;
        end
        S_DWELL: begin
          if (dwell_tc) begin
            beam_on <= 1'b0;
            if (!sprite_end) begin
              ptr    <= ptr + 1'b1;
              pt_cnt <= pt_cnt + 1'b1;
            end
          end else begin
            dwell_cnt <= dwell_cnt - 1'b1;
          end
        end
        S_NEXT: begin
          beam_on <= 1'b0;
          slot    <= slot + 1'b1;
        end
        S_DONE:  beam_on <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_entity_vector_sequencer.sv
// Directed bench for entity_vector_sequencer (default build, no cursor slot).
module tb_entity_vector_sequencer;
  localparam int W  = 8;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic frame_start = 1'b0;
  logic [W-1:0] xenemy1 = '0, yenemy1 = '0, xenemy2 = '0, yenemy2 = '0;
  logic [W-1:0] xenemy3 = '0, yenemy3 = '0, x_missile = '0, y_missile = '0;
  logic spawn_enemy1 = 1'b0, spawn_enemy2 = 1'b0, spawn_enemy3 = 1'b0, spawn_missile = 1'b0;
  logic [AW-1:0] adr_enemy1 = '0, adr_enemy2 = '0, adr_enemy3 = '0;
  logic [AW-1:0] rom_adr;
  logic rom_en;
  logic [2*W+1:0] rom_data = '0;
  logic [W-1:0] x_out, y_out;
  logic beam_on, busy, frame_done;

  logic [2*W+1:0] rom [0:255];

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] adr_q[$];
  logic [15:0]   pix_q[$];
  int            fd_cnt = 0;

  entity_vector_sequencer dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .xenemy1(xenemy1), .yenemy1(yenemy1), .xenemy2(xenemy2), .yenemy2(yenemy2),
    .xenemy3(xenemy3), .yenemy3(yenemy3),
    .spawn_enemy1(spawn_enemy1), .spawn_enemy2(spawn_enemy2), .spawn_enemy3(spawn_enemy3),
    .adr_enemy1(adr_enemy1), .adr_enemy2(adr_enemy2), .adr_enemy3(adr_enemy3),
    .x_missile(x_missile), .y_missile(y_missile), .spawn_missile(spawn_missile),
    .rom_adr(rom_adr), .rom_en(rom_en), .rom_data(rom_data),
    .x_out(x_out), .y_out(y_out), .beam_on(beam_on), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom_en ? rom[rom_adr[7:0]] : '0;

  always @(negedge clk) begin
    if (rom_en) adr_q.push_back(rom_adr);
    if (beam_on) pix_q.push_back({x_out, y_out});
    if (frame_done) fd_cnt++;
  end

  function automatic logic [2*W+1:0] w(input int dx, input int dy, input bit beam, input bit last);
    logic [7:0] a, b;
    a = dx[7:0];
    b = dy[7:0];
    return {a, b, beam, last};
  endfunction

  task automatic clear_inputs();
    spawn_enemy1 = 0; spawn_enemy2 = 0; spawn_enemy3 = 0; spawn_missile = 0;
    xenemy1 = 0; yenemy1 = 0; xenemy2 = 0; yenemy2 = 0; xenemy3 = 0; yenemy3 = 0;
    x_missile = 0; y_missile = 0;
    adr_enemy1 = 16'h0010; adr_enemy2 = 16'h0020; adr_enemy3 = 16'h0040;
    adr_q.delete();
    pix_q.delete();
  endtask

  task automatic run_frame(input int budget, output int cycles, output bit timeout);
    @(negedge clk);
    frame_start = 1'b1;
    cycles = 0;
    timeout = 1'b1;
    while (cycles < budget) begin
      @(negedge clk);
      frame_start = 1'b0;
      cycles++;
      if (frame_done) begin
        timeout = 1'b0;
        break;
      end
    end
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    checks++;
    if ({x_out, y_out} !== 16'h0000) begin
      errors++; $display("FAIL reset_xy: got %h want 0000", {x_out, y_out});
    end
    checks++;
    if ({beam_on, rom_en, busy, frame_done} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b want 0000", {beam_on, rom_en, busy, frame_done});
    end
    checks++;
    if (rom_adr !== 16'h0000) begin
      errors++; $display("FAIL reset_rom_adr: got %h want 0000", rom_adr);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL idle_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_single_enemy();
    int cyc; bit to; int bad;
    clear_inputs();
    spawn_enemy1 = 1; xenemy1 = 100; yenemy1 = 50;
    run_frame(200, cyc, to);
    checks++;
    if (to || cyc != 22) begin
      errors++; $display("FAIL enemy1_frame_len: got %0d (timeout %0b) want 22", cyc, to);
    end
    checks++;
    if (adr_q.size() != 2) begin
      errors++; $display("FAIL enemy1_rom_en_count: got %0d want 2", adr_q.size());
    end else begin
      checks++;
      if (adr_q[0] !== 16'h0010 || adr_q[1] !== 16'h0011) begin
        errors++; $display("FAIL enemy1_rom_adr: got %h,%h want 0010,0011", adr_q[0], adr_q[1]);
      end
    end
    checks++;
    if (pix_q.size() != 8) begin
      errors++; $display("FAIL enemy1_beam_cycles: got %0d want 8", pix_q.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 8; i++)
        if (pix_q[i] !== ((i < 4) ? {8'd102, 8'd47} : {8'd99, 8'd51})) bad++;
      checks++;
      if (bad != 0) begin
        errors++; $display("FAIL enemy1_points: %0d wrong samples, first %h want 662f", bad, pix_q[0]);
      end
    end
    checks++;
    if ({x_out, y_out, beam_on, busy} !== {8'd99, 8'd51, 1'b0, 1'b1}) begin
      errors++; $display("FAIL enemy1_hold_at_done: got x=%0d y=%0d beam=%b busy=%b want 99 51 0 1",
                         x_out, y_out, beam_on, busy);
    end
    @(negedge clk);
    checks++;
    if ({busy, frame_done} !== 2'b00) begin
      errors++; $display("FAIL enemy1_after_done: got busy=%b done=%b want 0 0", busy, frame_done);
    end
  endtask

  task automatic test_clamp();
    int cyc; bit to;
    clear_inputs();
    spawn_missile = 1; x_missile = 254; y_missile = 1;
    run_frame(200, cyc, to);
    checks++;
    if (to || cyc != 16) begin
      errors++; $display("FAIL clamp_frame_len: got %0d (timeout %0b) want 16", cyc, to);
    end
    checks++;
    if (adr_q.size() != 1 || pix_q.size() != 4) begin
      errors++; $display("FAIL clamp_counts: got rom_en %0d beam %0d want 1 4", adr_q.size(), pix_q.size());
    end else begin
      checks++;
      if (pix_q[0] !== {8'd255, 8'd0} || pix_q[3] !== {8'd255, 8'd0} || adr_q[0] !== 16'h0000) begin
        errors++; $display("FAIL clamp_point: got %h adr %h want ff00 adr 0000", pix_q[0], adr_q[0]);
      end
    end
  endtask

  task automatic test_all_inactive();
    int cyc; bit to;
    clear_inputs();
    run_frame(100, cyc, to);
    checks++;
    if (to || cyc != 10) begin
      errors++; $display("FAIL empty_frame_len: got %0d (timeout %0b) want 10", cyc, to);
    end
    checks++;
    if (adr_q.size() != 0 || pix_q.size() != 0) begin
      errors++; $display("FAIL empty_no_rom: got rom_en %0d beam %0d want 0 0", adr_q.size(), pix_q.size());
    end
  endtask

  task automatic test_snapshot();
    int cyc; bit to; int bad;
    clear_inputs();
    spawn_enemy2 = 1; xenemy2 = 30; yenemy2 = 10;
    fork
      run_frame(200, cyc, to);
      begin
        repeat (4) @(negedge clk);
        xenemy2 = 200;
      end
    join
    bad = 0;
    for (int i = 0; i < pix_q.size(); i++)
      if (pix_q[i] !== ((i < 4) ? {8'd30, 8'd10} : {8'd35, 8'd15})) bad++;
    checks++;
    if (to || pix_q.size() != 8 || bad != 0) begin
      errors++; $display("FAIL snapshot_old_anchor: samples %0d wrong %0d first %h want 8 0 1e0a",
                         pix_q.size(), bad, (pix_q.size() > 0) ? pix_q[0] : 16'h0);
    end
    adr_q.delete();
    pix_q.delete();
    run_frame(200, cyc, to);
    bad = 0;
    for (int i = 0; i < pix_q.size(); i++)
      if (pix_q[i] !== ((i < 4) ? {8'd200, 8'd10} : {8'd205, 8'd15})) bad++;
    checks++;
    if (to || pix_q.size() != 8 || bad != 0) begin
      errors++; $display("FAIL snapshot_new_anchor: samples %0d wrong %0d first %h want 8 0 c80a",
                         pix_q.size(), bad, (pix_q.size() > 0) ? pix_q[0] : 16'h0);
    end
  endtask

  task automatic test_runaway();
    int cyc; bit to;
    clear_inputs();
    spawn_enemy3 = 1; xenemy3 = 40; yenemy3 = 40;
    spawn_missile = 1; x_missile = 10; y_missile = 10;
    run_frame(1000, cyc, to);
    checks++;
    if (to) begin
      errors++; $display("FAIL runaway_done: no frame_done within 1000 cycles, got %0d want done", cyc);
    end
    checks++;
    if (adr_q.size() != 65) begin
      errors++; $display("FAIL runaway_rom_en_count: got %0d want 65", adr_q.size());
    end else begin
      checks++;
      if (adr_q[0] !== 16'h0040 || adr_q[63] !== 16'h007f || adr_q[64] !== 16'h0000) begin
        errors++; $display("FAIL runaway_adr: got %h %h %h want 0040 007f 0000",
                           adr_q[0], adr_q[63], adr_q[64]);
      end
    end
    checks++;
    if (pix_q.size() != 4 || (pix_q.size() > 0 && pix_q[0] !== {8'd15, 8'd6})) begin
      errors++; $display("FAIL runaway_next_slot: samples %0d first %h want 4 0f06",
                         pix_q.size(), (pix_q.size() > 0) ? pix_q[0] : 16'h0);
    end
  endtask

  task automatic test_reset_mid_dwell();
    int n; int cyc; bit to;
    clear_inputs();
    spawn_enemy1 = 1; xenemy1 = 100; yenemy1 = 50;
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    n = 0;
    while (beam_on !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (beam_on !== 1'b1) begin
      errors++; $display("FAIL mid_dwell_reach: beam_on %b after %0d cycles want 1", beam_on, n);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({x_out, y_out, beam_on, rom_en, rom_adr, busy, frame_done} !== '0) begin
      errors++; $display("FAIL mid_dwell_async_reset: got x=%0d y=%0d beam=%b en=%b adr=%h busy=%b done=%b want all 0",
                         x_out, y_out, beam_on, rom_en, rom_adr, busy, frame_done);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    fd_cnt = 0;
    repeat (30) @(negedge clk);
    checks++;
    if (fd_cnt != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_dwell_no_done: got frame_done %0d busy %b want 0 0", fd_cnt, busy);
    end
    pix_q.delete();
    run_frame(200, cyc, to);
    checks++;
    if (to || cyc != 22 || pix_q.size() != 8) begin
      errors++; $display("FAIL mid_dwell_recover: got len %0d beam %0d want 22 8", cyc, pix_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = '0;
    rom[8'h00] = w(5, -4, 1'b1, 1'b1);
    rom[8'h10] = w(2, -3, 1'b1, 1'b0);
    rom[8'h11] = w(-1, 1, 1'b1, 1'b1);
    rom[8'h20] = w(0, 0, 1'b1, 1'b0);
    rom[8'h21] = w(5, 5, 1'b1, 1'b1);
    for (int i = 8'h40; i < 8'h80; i++) rom[i] = w(1, 0, 1'b0, 1'b0);
    rom[8'h80] = w(0, 0, 1'b1, 1'b1);
    clear_inputs();

    test_reset();
    test_single_enemy();
    test_clamp();
    test_all_inactive();
    test_snapshot();
    test_runaway();
    test_reset_mid_dwell();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
